pipelined_shift_unit: RTL and testbench
=======================================

// Module: pipelined_shift_unit
// PURPOSE
//   Parametrised two-stage barrel shifter and field extender for the data path.
//   Shifts, rotates and sign/zero-extends an operand, producing an ARM-style shifter
//   carry-out. Sits between register read and the ALU shifter-operand input.
//   Uses a valid/ready handshake so the pipeline control can stall it.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; must be a power of two and >= 8
//   AMT_W  8   shift-amount width; amounts up to 2**AMT_W-1 are legal
// PORTS
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous, active-high reset
//   in_valid    in   1      request present on the in_* fields
//   in_ready    out  1      unit accepts a request this cycle
//   in_op       in   3      000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX, 101 SEXT, 110 ZEXT, 111 PASS
//   in_operand  in   WIDTH  value to shift or extend (Rm or immediate)
//   in_amount   in   AMT_W  shift amount, or field width for SEXT/ZEXT
//   in_carry    in   1      current C flag
//   out_valid   out  1      result present
//   out_ready   in   1      consumer takes the result this cycle
//   out_result  out  WIDTH  shifted or extended value
//   out_carry   out  1      shifter carry-out
// BEHAVIOUR
//   - Reset: all stage valids are cleared, so out_valid=0. out_result=0, out_carry=0.
//     in_ready=1 in the cycle after reset deasserts.
//   - Reset mid-operation: every in-flight request is dropped. Nothing is emitted later.
//   - Pipeline: S1 registers the request and performs the coarse shift (upper amount bits).
//     S2 performs the fine shift and the carry, and drives out_*.
//   - Latency: 2 cycles from acceptance (in_valid & in_ready) to out_valid. Throughput 1/cycle.
//   - Stall rules: S2 holds while out_valid & !out_ready. S1 advances only if S2 is empty
//     or draining. in_ready = !s1_valid | s1_advance, which is combinational from out_ready.
//   - out_* stay stable while out_valid & !out_ready.
//   - A request is accepted and emitted exactly once, in order. No drops, no duplicates.
//   - Let n = in_amount, W = WIDTH, s = op[W-1] (operand sign bit).
//   - n == 0, shift/rotate ops: result = op, carry = in_carry.
//   - LSL:
//       * 0<n<W: op<<n, carry = op[W-n]
//       * n==W: result 0, carry = op[0]
//       * n>W: result 0, carry 0
//   - LSR:
//       * 0<n<W: op>>n, carry = op[n-1]
//       * n==W: result 0, carry = s
//       * n>W: result 0, carry 0
//   - ASR:
//       * 0<n<W: arithmetic op>>>n, carry = op[n-1]
//       * n>=W: result = all bits equal s, carry = s
//   - ROR, with m = n mod W:
//       * m!=0: rotate right by m, carry = op[m-1]
//       * m==0 and n!=0: result = op, carry = s
//   - RRX: ignores n. Result = {in_carry, op[W-1:1]}, carry = op[0].
//   - SEXT/ZEXT: n is the field width.
//       * 1<=n<W: sign- (or zero-) extend op[n-1:0] to W bits
//       * n==0 or n>=W: result = op
//       * carry = in_carry
//   - PASS: result = op, carry = in_carry.
//   - All arithmetic is unsigned on in_amount. Out-of-range amounts never index outside the operand.
// TESTING
//   1. Reset with in_valid held high, then release -> no out_valid until 2 cycles after first accept.
//   2. LSL op=32'h8000_0001:
//        n=1 -> 32'h0000_0002, c=1
//        n=32 -> 0, c=1
//        n=33 -> 0, c=0
//   3. ASR op=32'h8000_0000:
//        n=4 -> 32'hF800_0000, c=0
//        n=40 -> 32'hFFFF_FFFF, c=1
//      ROR op=32'h0000_00F1:
//        n=4 -> 32'h1000_000F, c=0
//        n=32 -> 32'h0000_00F1, c=0
//   4. RRX op=32'h0000_0003, in_carry=1 -> 32'h8000_0001, c=1.
//      SEXT op=32'h0000_0080, n=8 -> 32'hFFFF_FF80.
//      ZEXT op=32'hFFFF_FF80, n=8 -> 32'h0000_0080.
//   5. Back-to-back stream of 8 requests with out_ready toggled randomly -> results in order,
//      none lost or duplicated, out_* stable while stalled.
//   6. Assert reset with both stages full -> out_valid=0 next cycle and neither request ever appears.

Source files
------------

// File: rtl/pipelined_shift_unit.sv
// Two-stage barrel shifter / field extender feeding the ALU shifter operand.
// S1 does the coarse (multiple-of-8) shift, S2 the fine shift and carry-out.
module pipelined_shift_unit #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_operand,
  input  logic [AMT_W-1:0] in_amount,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry
);

  localparam int LG = $clog2(WIDTH);
  localparam logic [31:0] WU = 32'(WIDTH);

  typedef enum logic [2:0] {
    K_BYP,
    K_LSL,
    K_LSR,
    K_ASR,
    K_ROR
  } kind_e;

  typedef struct packed {
    kind_e          kind;
    logic [WIDTH:0] x;
    logic [2:0]     fine;
    logic           c;
  } s1_t;

  function automatic logic [WIDTH-1:0] rotr(
    input logic [WIDTH-1:0] v,
    input logic [LG-1:0]    s
  );
    logic [31:0] l;
    l = WU - 32'(s);
    return (v >> s) | (v << l);
  endfunction

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_advance;
  s1_t              s1_d;
  s1_t              s1_q;
  logic [WIDTH-1:0] s2_res;
  logic             s2_c;
  logic [WIDTH:0]   y;

  logic             op_lsl, op_lsr, op_asr, op_ror;
  logic             op_rrx, op_ext, op_sext, op_pass;
  logic [31:0]      n32;
  logic             zero_n;
  logic             big;
  logic             wide;
  logic [LG:0]      k;
  logic [LG:0]      kc;
  logic [LG-1:0]    m;
  logic [LG-1:0]    mc;
  logic [LG-1:0]    fidx;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] low;

  assign op_lsl  = (in_op == 3'b000);
  assign op_lsr  = (in_op == 3'b001);
  assign op_asr  = (in_op == 3'b010);
  assign op_ror  = (in_op == 3'b011);
  assign op_rrx  = (in_op == 3'b100);
  assign op_sext = (in_op == 3'b101);
  assign op_ext  = (in_op == 3'b101) || (in_op == 3'b110);
  assign op_pass = (in_op == 3'b111);

  assign n32    = 32'(in_amount);
  assign zero_n = (n32 == 32'd0);
  assign big    = (n32 > WU);
  assign wide   = (n32 >= WU);
  // Clamp to W so the shift amount never exceeds the operand
  assign k      = wide ? WU[LG:0] : n32[LG:0];
  assign kc     = k & ~(LG+1)'(7);
  assign m      = n32[LG-1:0];
  assign mc     = m & ~LG'(7);
  assign fidx   = m - LG'(1);
  assign mask   = ~({WIDTH{1'b1}} << m);
  assign low    = in_operand & mask;

  always_comb begin
    s1_d      = '0;
    s1_d.kind = K_BYP;
    s1_d.x    = {1'b0, in_operand};
    s1_d.c    = in_carry;
    unique case (1'b1)
      op_lsl: begin
        if (big) begin
          s1_d.x = '0;
          s1_d.c = 1'b0;
        end else if (!zero_n) begin
          s1_d.kind = K_LSL;
          s1_d.x    = {1'b0, in_operand} << kc;
          s1_d.fine = k[2:0];
        end
      end
      op_lsr: begin
        if (big) begin
          s1_d.x = '0;
          s1_d.c = 1'b0;
        end else if (!zero_n) begin
          s1_d.kind = K_LSR;
          s1_d.x    = {in_operand, 1'b0} >> kc;
          s1_d.fine = k[2:0];
        end
      end
      op_asr: begin
        if (!zero_n) begin
          s1_d.kind = K_ASR;
          s1_d.x    = $signed({in_operand, 1'b0}) >>> kc;
          s1_d.fine = k[2:0];
        end
      end
      op_ror: begin
        if (!zero_n) begin
          s1_d.kind = K_ROR;
          s1_d.x    = {1'b0, rotr(in_operand, mc)};
          s1_d.fine = m[2:0];
        end
      end
      op_rrx: begin
        s1_d.x = {1'b0, in_carry, in_operand[WIDTH-1:1]};
        s1_d.c = in_operand[0];
      end
      op_ext: begin
        if (!zero_n && !wide) begin
          s1_d.x = {1'b0, (op_sext && in_operand[fidx]) ? (low | ~mask) : low};
        end
      end
      op_pass: begin
      end
      default: begin
      end
    endcase
  end

  // The extra bit of x carries the last bit shifted out
  always_comb begin
    y      = '0;
    s2_res = s1_q.x[WIDTH-1:0];
    s2_c   = s1_q.c;
    unique case (s1_q.kind)
      K_LSL: begin
        y      = s1_q.x << s1_q.fine;
        s2_res = y[WIDTH-1:0];
        s2_c   = y[WIDTH];
      end
      K_LSR: begin
        y      = s1_q.x >> s1_q.fine;
        s2_res = y[WIDTH:1];
        s2_c   = y[0];
      end
      K_ASR: begin
        y      = $signed(s1_q.x) >>> s1_q.fine;
        s2_res = y[WIDTH:1];
        s2_c   = y[0];
      end
      K_ROR: begin
        s2_res = rotr(s1_q.x[WIDTH-1:0], LG'(s1_q.fine));
        s2_c   = s2_res[WIDTH-1];
      end
      default: begin
      end
    endcase
  end

  assign s1_advance = s1_valid && (!s2_valid || out_ready);
  assign in_ready   = !s1_valid || s1_advance;
  assign out_valid  = s2_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_q       <= '0;
      out_result <= '0;
      out_carry  <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s1_advance) begin
        s2_valid   <= 1'b1;
        out_result <= s2_res;
        out_carry  <= s2_c;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Directed bench for pipelined_shift_unit: reset, op vectors,
// a stalled stream and reset with both stages occupied.
module tb_pipelined_shift_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_operand;
  logic [7:0]  in_amount;
  logic        in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carry;

  int total = 0;
  int bad = 0;

  pipelined_shift_unit #(.WIDTH(32), .AMT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_operand (in_operand),
    .in_amount  (in_amount),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Entered on a negedge with the pipeline empty and out_ready high
  task automatic vec(input string tag, input logic [2:0] op,
                     input logic [31:0] a, input logic [7:0] n,
                     input logic c, input logic [31:0] er,
                     input logic ec);
    int cyc;
    in_valid   = 1'b1;
    in_op      = op;
    in_operand = a;
    in_amount  = n;
    in_carry   = c;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(2));
    chk(tag, 64'({out_result, out_carry}), 64'({er, ec}));
    @(negedge clk);
  endtask

  logic [7:0]  s_amt [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd31, 8'd32};
  logic [31:0] s_res [8] = '{32'h6, 32'hC, 32'h18, 32'h30, 32'h60, 32'hC0,
                             32'h8000_0000, 32'h0};
  logic        s_c   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int sent;
    int got;
    int cyc;
    logic stall;
    logic seen;
    logic [31:0] hold_r;
    logic hold_c;

    reset      = 1'b1;
    in_valid   = 1'b1;
    in_op      = 3'b111;
    in_operand = 32'h1234_5678;
    in_amount  = 8'd0;
    in_carry   = 1'b1;
    out_ready  = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_vld", 64'(out_valid), 64'(0));
    chk("rst_res", 64'({out_result, out_carry}), 64'(0));
    reset = 1'b0;
    #1;
    chk("rdy_after_rst", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat1_vld", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("lat2_vld", 64'(out_valid), 64'(1));
    chk("lat2_res", 64'({out_result, out_carry}), 64'({32'h1234_5678, 1'b1}));
    @(negedge clk);
    chk("drain", 64'(out_valid), 64'(0));

    vec("lsl1",   3'b000, 32'h8000_0001, 8'd1,   1'b0, 32'h0000_0002, 1'b1);
    vec("lsl32",  3'b000, 32'h8000_0001, 8'd32,  1'b0, 32'h0,         1'b1);
    vec("lsl33",  3'b000, 32'h8000_0001, 8'd33,  1'b1, 32'h0,         1'b0);
    vec("lsl200", 3'b000, 32'hFFFF_FFFF, 8'd200, 1'b1, 32'h0,         1'b0);
    vec("lsl0",   3'b000, 32'h0000_0055, 8'd0,   1'b1, 32'h0000_0055, 1'b1);
    vec("lsr4",   3'b001, 32'h0000_00F8, 8'd4,   1'b0, 32'h0000_000F, 1'b1);
    vec("lsr32",  3'b001, 32'h8000_0000, 8'd32,  1'b0, 32'h0,         1'b1);
    vec("asr4",   3'b010, 32'h8000_0000, 8'd4,   1'b1, 32'hF800_0000, 1'b0);
    vec("asr40",  3'b010, 32'h8000_0000, 8'd40,  1'b0, 32'hFFFF_FFFF, 1'b1);
    vec("asr40p", 3'b010, 32'h7000_0000, 8'd40,  1'b1, 32'h0,         1'b0);
    vec("ror4",   3'b011, 32'h0000_00F1, 8'd4,   1'b1, 32'h1000_000F, 1'b0);
    vec("ror32",  3'b011, 32'h0000_00F1, 8'd32,  1'b1, 32'h0000_00F1, 1'b0);
    vec("ror36",  3'b011, 32'h0000_00F1, 8'd36,  1'b0, 32'h1000_000F, 1'b0);
    vec("ror12",  3'b011, 32'h0000_0F00, 8'd12,  1'b0, 32'hF000_0000, 1'b1);
    vec("rrx",    3'b100, 32'h0000_0003, 8'd7,   1'b1, 32'h8000_0001, 1'b1);
    vec("sext8",  3'b101, 32'h0000_0080, 8'd8,   1'b0, 32'hFFFF_FF80, 1'b0);
    vec("sext8p", 3'b101, 32'h0000_017F, 8'd8,   1'b1, 32'h0000_007F, 1'b1);
    vec("sext0",  3'b101, 32'h0000_0080, 8'd0,   1'b0, 32'h0000_0080, 1'b0);
    vec("zext8",  3'b110, 32'hFFFF_FF80, 8'd8,   1'b1, 32'h0000_0080, 1'b1);
    vec("zext32", 3'b110, 32'hFFFF_FF80, 8'd32,  1'b0, 32'hFFFF_FF80, 1'b0);
    vec("pass",   3'b111, 32'hDEAD_BEEF, 8'd9,   1'b0, 32'hDEAD_BEEF, 1'b0);

    sent  = 0;
    got   = 0;
    cyc   = 0;
    stall = 1'b0;
    hold_r = '0;
    hold_c = 1'b0;
    while (got < 8 && cyc < 200) begin
      if (stall)
        chk("stable", 64'({out_valid, out_result, out_carry}),
            64'({1'b1, hold_r, hold_c}));
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_op      = 3'b000;
        in_operand = 32'h0000_0003;
        in_amount  = s_amt[sent];
        in_carry   = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        chk($sformatf("strm%0d", got), 64'({out_result, out_carry}),
            64'({s_res[got], s_c[got]}));
        got++;
      end
      if (in_valid && in_ready) sent++;
      stall  = out_valid && !out_ready;
      hold_r = out_result;
      hold_c = out_carry;
      @(negedge clk);
      cyc++;
    end
    chk("strm_cnt", 64'(got), 64'(8));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("strm_nodup", 64'(seen), 64'(0));

    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_op      = 3'b111;
    in_operand = 32'hAAAA_0001;
    in_carry   = 1'b0;
    @(negedge clk);
    in_operand = 32'hAAAA_0002;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full_vld", 64'(out_valid), 64'(1));
    chk("full_rdy", 64'(in_ready), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("flush_vld", 64'(out_valid), 64'(0));
    chk("flush_res", 64'({out_result, out_carry}), 64'(0));
    reset     = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("flush_ghost", 64'(seen), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
